// File: rtl/ext_link_rx.sv
// Receive side of the external serial link: deserialises 8N1-style frames and
// returns a timed acknowledge pulse to the peer transmitter after each good frame.
module ext_link_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ACK_BITS     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              receiver_en,
  input  logic              ext_data_in,
  output logic              ack_out,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              busy,
  output logic [2:0]        state_rx
);

  localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW   = $clog2(DATA_W + 1);
  localparam logic [TimerW-1:0] TimerHalf = TimerW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TimerW-1:0] TimerFull = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]   BitsLast  = BitW'(DATA_W - 1);
  // The ack reuses the bit counter, so ACK_BITS must not exceed DATA_W.
  localparam logic [BitW-1:0]   AckLast   = BitW'(ACK_BITS - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StAck   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic                ack_q;
  logic                sync1_q, sync2_q, prev_q;
  logic                line, fall;

  assign line = sync2_q;
  assign fall = prev_q & ~sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= ext_data_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TimerW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      StIdle: begin
        timer_d = '0;
        if (receiver_en && fall) state_d = StStart;
      end
      StStart: begin
        if (!receiver_en) begin
          state_d = StIdle;
        end else if (timer_q == TimerHalf) begin
          state_d = line ? StIdle : StData;
        end
      end
      StData: begin
        if (!receiver_en) begin
          state_d = StIdle;
        end else if (timer_q == TimerFull) begin
          shift_d   = {line, shift_q[DATA_W-1:1]};
          timer_d   = '0;
          bit_cnt_d = bit_cnt_q + BitW'(1);
          if (bit_cnt_q == BitsLast) state_d = StStop;
        end
      end
      StStop: begin
        if (!receiver_en) begin
          state_d = StIdle;
        end else if (timer_q == TimerFull) begin
          if (line) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StAck;
          end else begin
            ferr_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StAck: begin
        // Ignores receiver_en so the peer always sees a complete ack.
        if (timer_q == TimerFull) begin
          timer_d   = '0;
          bit_cnt_d = bit_cnt_q + BitW'(1);
          if (bit_cnt_q == AckLast) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) begin
      timer_d   = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      // Lags the ACK state by one cycle, so it rises right after data_valid.
      ack_q     <= (state_q == StAck);
    end
  end

  assign ack_out    = ack_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != StIdle);
  assign state_rx   = state_q;

endmodule

// File: tb/tb_ext_link_rx.sv
// Randomised bench for ext_link_rx: frames are built as cycle-level line waveforms and the
// observed pulses are compared with outcomes derived from the framing rules.
module tb_ext_link_rx;
  localparam int unsigned Cpb      = 16;
  localparam int unsigned Dw       = 8;
  localparam int unsigned Ab       = 2;
  localparam int          FrameLen = 190;
  localparam int          ValidAt  = 155;  // 3 sync/edge + 8 half-start + 8*16 data + 16 stop

  logic          clk = 1'b0;
  logic          reset, receiver_en, ext_data_in;
  logic          ack_out, data_valid, frame_err, busy;
  logic [Dw-1:0] data_out;
  logic [2:0]    state_rx;

  always #5 clk = ~clk;

  ext_link_rx #(.CLKS_PER_BIT(Cpb), .DATA_W(Dw), .ACK_BITS(Ab)) dut (
    .clk        (clk),
    .reset      (reset),
    .receiver_en(receiver_en),
    .ext_data_in(ext_data_in),
    .ack_out    (ack_out),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .state_rx   (state_rx)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit          line_q[$];
  bit          en_q[$];
  logic [7:0]  model_data = '0;
  int          n_valid, n_ferr, n_ack, valid_at, ferr_at, ack_first, ack_last, overlap;
  logic [7:0]  st_mask;
  bit          busy_hist[FrameLen+1];

  task automatic build(input logic [7:0] b, input bit stop, input int drop_at, input int glitch);
    line_q.delete();
    en_q.delete();
    if (glitch > 0) begin
      for (int i = 0; i < glitch; i++) line_q.push_back(1'b0);
    end else begin
      for (int i = 0; i < int'(Cpb); i++) line_q.push_back(1'b0);
      for (int j = 0; j < int'(Dw); j++)
        for (int i = 0; i < int'(Cpb); i++) line_q.push_back(b[j]);
      for (int i = 0; i < int'(Cpb); i++) line_q.push_back(stop);
    end
    while (line_q.size() < FrameLen) line_q.push_back(1'b1);
    for (int i = 0; i < FrameLen; i++) en_q.push_back(!(drop_at >= 0 && i >= drop_at));
  endtask

  task automatic play(input int n);
    n_valid = 0; n_ferr = 0; n_ack = 0; overlap = 0;
    valid_at = -1; ferr_at = -1; ack_first = -1; ack_last = -1; st_mask = '0;
    for (int i = 0; i < n; i++) begin
      ext_data_in = line_q[i];
      receiver_en = en_q[i];
      @(posedge clk);
      #1;
      busy_hist[i+1] = busy;
      st_mask[state_rx] = 1'b1;
      if (data_valid) begin n_valid++; valid_at = i + 1; end
      if (frame_err) begin n_ferr++; ferr_at = i + 1; end
      if (data_valid && frame_err) overlap++;
      if (ack_out) begin
        n_ack++;
        if (ack_first < 0) ack_first = i + 1;
        ack_last = i + 1;
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input bit stop, input int drop_at,
                           input int glitch);
    bit active, exp_valid, exp_ferr;
    active    = (glitch == 0) && (drop_at < 0);
    exp_valid = active && stop;
    exp_ferr  = active && !stop;
    if (exp_valid) model_data = b;
    build(b, stop, drop_at, glitch);
    play(FrameLen);
    check_eq("valid_cnt", n_valid, exp_valid);
    check_eq("ferr_cnt", n_ferr, exp_ferr);
    check_eq("ack_cycles", n_ack, exp_valid ? Ab * Cpb : 0);
    check_eq("valid_ferr_overlap", overlap, 0);
    check_eq("data_out", data_out, model_data);
    check_eq("end_state", state_rx, 0);
    if (exp_valid) begin
      check_eq("valid_at", valid_at, ValidAt);
      check_eq("ack_first", ack_first, ValidAt + 1);
      check_eq("ack_contig", ack_last - ack_first + 1, Ab * Cpb);
    end
    if (exp_ferr) check_eq("ferr_at", ferr_at, ValidAt);
    if (drop_at == 0) check_eq("busy_while_disabled", st_mask, 8'h01);
    if (drop_at > 0) begin
      check_eq("busy_before_drop", busy_hist[drop_at], 1'b1);
      check_eq("idle_after_drop", busy_hist[drop_at+1], 1'b0);
    end
    if (glitch > 0) check_eq("glitch_states", st_mask, 8'h03);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_state"}, state_rx, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_ack"}, ack_out, 0);
    check_eq({tag, "_data"}, data_out, 0);
    check_eq({tag, "_valid"}, data_valid, 0);
    check_eq({tag, "_ferr"}, frame_err, 0);
  endtask

  task automatic release_reset();
    ext_data_in = 1'b1;
    receiver_en = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int mode;
    reset = 1'b0;
    receiver_en = 1'b1;
    ext_data_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    release_reset();

    run_frame(8'hA5, 1'b1, -1, 0);
    run_frame(8'h00, 1'b1, -1, 0);
    run_frame(8'hFF, 1'b1, -1, 0);
    run_frame(8'h3C, 1'b0, -1, 0);
    run_frame(8'h00, 1'b1, -1, 4);
    run_frame(8'h5A, 1'b1, 0, 0);
    run_frame(8'h5A, 1'b1, 60, 0);

    // Asynchronous reset mid-DATA: checked before the next clock edge.
    build(8'h77, 1'b1, -1, 0);
    play(80);
    #1 reset = 1'b0;
    #1 check_reset_outputs("rst_data");
    model_data = '0;
    release_reset();

    run_frame(8'h99, 1'b1, -1, 0);
    build(8'h66, 1'b1, -1, 0);
    play(170);
    check_eq("ack_before_rst", ack_out, 1'b1);
    #1 reset = 1'b0;
    #1 check_reset_outputs("rst_ack");
    model_data = '0;
    release_reset();
    run_frame(8'h81, 1'b1, -1, 0);

    for (int n = 0; n < 20; n++) begin
      mode = $urandom_range(0, 9);
      case (mode)
        0:       run_frame(8'h00, 1'b1, -1, $urandom_range(1, 6));
        1:       run_frame(8'($urandom), 1'b1, $urandom_range(5, 150), 0);
        2:       run_frame(8'($urandom), 1'b1, 0, 0);
        3:       run_frame(8'($urandom), 1'b0, -1, 0);
        default: run_frame(8'($urandom), 1'b1, -1, 0);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ext_link_rx.md
Name: ext_link_rx

Overview:
- Receiving end of the external serial link. Deserialises frames arriving on ext_data_in from a peer board's transmitter over GPIO.
- After each good frame it presents the byte to the local bus side and returns an acknowledge pulse on ack_out. That pulse is what the peer transmitter watches on its ack_in.
- Sits in top beside the link transmitter. It is gated by receiver_en, which comes from a switch in the board wrapper.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200). Must be >= 4.
- DATA_W, 8, data bits per frame, sent LSB first.
- ACK_BITS, 2, length of the ack_out pulse in bit periods.

Ports:
- clk  input  1  system clock; all flops on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- receiver_en  input  1  1 = accept frames; 0 = ignore the line.
- ext_data_in  input  1  serial line, asynchronous to clk; idle level 1.
- ack_out  output  1  acknowledge to the peer transmitter; 1 for ACK_BITS*CLKS_PER_BIT cycles.
- data_out  output  DATA_W  last good received byte; holds until the next good frame.
- data_valid  output  1  one-cycle pulse when data_out updates.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- busy  output  1  1 in any state other than IDLE.
- state_rx  output  3  FSM state for LED debug: IDLE=0, START=1, DATA=2, STOP=3, ACK=4.

Behaviour:
- Reset values (reset=0, applied asynchronously, also mid-frame): state IDLE, ack_out=0, data_out=0, data_valid=0, frame_err=0, busy=0, synchroniser flops=1, all counters=0.
- Synchroniser: 2-flop synchroniser on ext_data_in, giving 2 cycles of latency. A third flop holds the previous value for falling-edge detection.
- Bit-timer counter width is clog2(CLKS_PER_BIT). Bit counter width is clog2(DATA_W+1). Counters clear on every state entry.
- IDLE:
  - On a synced falling edge with receiver_en=1, go to START.
  - A line that is already low does not trigger START; a falling edge is required.
- START:
  - At timer = CLKS_PER_BIT/2 - 1 (integer division), sample the line.
  - Line 0: go to DATA with timer cleared.
  - Line 1 (glitch): return to IDLE and raise no flags.
- DATA:
  - At each timer = CLKS_PER_BIT-1, shift the sampled bit in at the MSB. Shift right, so after DATA_W shifts bit0 is the first bit received.
  - After DATA_W samples, go to STOP.
- STOP: at timer = CLKS_PER_BIT-1, sample the line.
  - Line 1: load data_out from the shift register, pulse data_valid for 1 cycle, go to ACK.
  - Line 0: pulse frame_err for 1 cycle, leave data_out unchanged, go to IDLE without an ack.
- ACK:
  - ack_out=1 for exactly ACK_BITS*CLKS_PER_BIT cycles, then ack_out=0 and go to IDLE.
  - Line edges during ACK are ignored.
- receiver_en falling to 0 in START, DATA or STOP:
  - Abort to IDLE on the next clock.
  - No data_valid, no frame_err; data_out is unchanged.
- receiver_en falling to 0 in ACK: the ack completes anyway, so the peer is never left half-acknowledged.
- data_valid and frame_err are never asserted in the same cycle.
- ack_out is registered and glitch-free; it goes high on the cycle after data_valid.

Test Plan:
Bench uses CLKS_PER_BIT=16, DATA_W=8, ACK_BITS=2, with the line driven from the falling start edge at cycle 0.
1. Frame 0xA5, receiver_en=1, good stop bit -> data_out=0xA5 with data_valid pulsing once at cycle 155±2; ack_out=1 for exactly 32 cycles starting the next cycle; state_rx returns to 0.
2. Frames 0x00 then 0xFF back-to-back, next start edge right after the ack ends -> data_out=0x00 then 0xFF, two data_valid pulses, two 32-cycle ack pulses.
3. Frame 0x3C with stop bit forced to 0 -> frame_err pulses once; data_out keeps its previous value; ack_out stays 0; FSM is back in IDLE.
4. Low glitch of 4 cycles on an idle line -> state_rx goes 1 then back to 0; no data_valid, frame_err or ack_out.
5. receiver_en=0 during a full 0x5A frame -> busy stays 0; no outputs change. Separately, dropping receiver_en mid-DATA -> IDLE next cycle with no pulses.
6. reset=0 asserted mid-DATA and during ACK -> all outputs go to reset values immediately without waiting for clk; after release, a 0x81 frame is received correctly.
